// File: rtl/darwin_tx_pkg.sv
// Shared constants, FSM state encoding and byte-keep helper for the darwin_tx
// host-stream to two-phase chip transmitter.
package darwin_tx_pkg;

   localparam int DEF_FIFO_DEPTH  = 8;
   localparam int DEF_ACK_TIMEOUT = 1024;

   localparam int DATA_W  = 16;
   localparam int ENTRY_W = DATA_W + 1;

   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_WAIT_ACK = 1'b1;

   // Bytes whose keep bit is clear are stored as 0x00.
   function automatic logic [DATA_W-1:0] keep_mask(input logic [DATA_W-1:0] data,
                                                   input logic [1:0]        keep);
      return {keep[1] ? data[15:8] : 8'h00, keep[0] ? data[7:0] : 8'h00};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and combinational head read.
module sync_fifo
   import darwin_tx_pkg::*;
#(
   parameter int WIDTH = ENTRY_W,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/darwin_tx.sv
// Buffers AXI-stream words and hands them to the chip over a two-phase
// REQ/ACK link, counting completions and flagging acknowledge timeouts.
module darwin_tx
   import darwin_tx_pkg::*;
#(
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] S_AXIS_TDATA,
   input  logic [1:0]  S_AXIS_TKEEP,
   input  logic        S_AXIS_TLAST,
   input  logic        S_AXIS_TVALID,
   output logic        S_AXIS_TREADY,
   output logic [15:0] TX_DATA,
   output logic        TX_REQ,
   input  logic        TX_ACK,
   output logic        TX_DONE,
   output logic [31:0] TX_COUNT,
   output logic        TX_TIMEOUT
);

   localparam logic [31:0] TIMEOUT_LIM = 32'(ACK_TIMEOUT);

   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_push;
   logic               fifo_pop;
   logic [ENTRY_W-1:0] fifo_din;
   logic [ENTRY_W-1:0] fifo_dout;

   logic               ack_meta;
   logic               ack_s;
   logic [0:0]         state;
   logic               cur_last;
   logic [31:0]        wait_cnt;
   logic               complete;
   logic               load;

   assign S_AXIS_TREADY = !fifo_full && !rst;
   assign fifo_push     = S_AXIS_TVALID && S_AXIS_TREADY && (S_AXIS_TKEEP != 2'b00);
   assign fifo_din      = {S_AXIS_TLAST, keep_mask(S_AXIS_TDATA, S_AXIS_TKEEP)};

   // An ack level change only matters while a request is outstanding.
   assign complete = (state == ST_WAIT_ACK) && (ack_s == TX_REQ);
   assign load     = !fifo_empty && ((state == ST_IDLE) || complete);
   assign fifo_pop = load && !rst;

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_meta <= 1'b0;
         ack_s    <= 1'b0;
      end else begin
         ack_meta <= TX_ACK;
         ack_s    <= ack_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         TX_DATA    <= '0;
         TX_REQ     <= 1'b0;
         TX_DONE    <= 1'b0;
         TX_COUNT   <= '0;
         TX_TIMEOUT <= 1'b0;
         cur_last   <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         TX_DONE <= 1'b0;
         if (complete) begin
            TX_COUNT <= TX_COUNT + 32'd1;
            TX_DONE  <= cur_last;
            if (!load) state <= ST_IDLE;
         end else if (state == ST_WAIT_ACK) begin
            if (wait_cnt != TIMEOUT_LIM)       wait_cnt   <= wait_cnt + 32'd1;
            if (wait_cnt == TIMEOUT_LIM - 32'd1) TX_TIMEOUT <= 1'b1;
         end
         // A new word goes out from IDLE or back-to-back on a completion edge.
         if (load) begin
            TX_DATA  <= fifo_dout[DATA_W-1:0];
            cur_last <= fifo_dout[DATA_W];
            TX_REQ   <= ~TX_REQ;
            wait_cnt <= '0;
            state    <= ST_WAIT_ACK;
         end
      end
   end

endmodule
